calc_key_sequencer: RTL
=======================

Name: calc_key_sequencer

Overview:
Initiator side of the 4-bit keypad protocol used by the FSMD calculator. It accepts a complete command (operand A, opcode, operand B) over a valid/ready handshake. It serialises the command into three single-cycle valid_key strobes on key[3:0], waits for the calculator's done, and returns the captured 8-bit result over a valid/ready response handshake. It sits between a test/host controller and the calculator.

Parameters:
GAP_CYCLES, 2, idle cycles (valid_key=0, key held) after each strobe; legal range 1..15
TIMEOUT_CYCLES, 16, cycles waited for done before error response (used only with KEYSEQ_TIMEOUT_EN)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  block can accept a command
cmd_a  input  4  operand A
cmd_op  input  2  00 add, 01 sub, 10 mul, 11 reserved
cmd_b  input  4  operand B
valid_key  output  1  key strobe to calculator
key  output  4  key value to calculator
done  input  1  calculator result valid
result  input  8  calculator result
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed
rsp_result  output  8  captured result
rsp_err  output  1  reserved opcode, or timeout

Behaviour:
- Reset is asynchronous, active-low, with clock clk. While rstn=0: state IDLE; valid_key=0, key=0, rsp_valid=0, rsp_result=0, rsp_err=0; cmd_ready=1 after release.
- Reset mid-operation aborts the sequence immediately with no partial response. The calculator shares rstn.
- All outputs are registered except cmd_ready, which equals (state==IDLE).
- States: IDLE, LOAD_A, STB_A, GAP_A, LOAD_OP, STB_OP, GAP_OP, LOAD_B, STB_B, GAP_B, WAIT_DONE, RESP.
- IDLE: on cmd_valid&&cmd_ready, capture cmd_a/op/b.
  - If op=11: go to RESP with rsp_err=1 and rsp_result=0. No strobe is ever issued.
  - Otherwise go to LOAD_A.
- LOAD_x: 1 cycle. key = value (A, {2'b00,op}, or B); valid_key=0.
- STB_x: exactly 1 cycle with valid_key=1, key unchanged. A strobe is never wider than 1 cycle and never back-to-back.
- GAP_x: GAP_CYCLES cycles with valid_key=0 and key held. Then go to the next LOAD, or to WAIT_DONE after GAP_B.
- key changes only on entering a LOAD state. It keeps its last value in WAIT_DONE, RESP and IDLE.
- done/result are ignored outside WAIT_DONE. A done left high from the previous calculation therefore cannot be mistaken for the current one.
- WAIT_DONE: on the first cycle done=1, capture rsp_result=result and rsp_err=0, then go to RESP.
- RESP: rsp_valid=1, and rsp_result/rsp_err are held stable until rsp_ready=1. Return to IDLE on the cycle after the handshake, with rsp_valid=0.
- Arithmetic: none inside the block. The result is passed through unmodified, 8 bits.
- Latency, counted in rising edges after the accept edge, with GAP_CYCLES=G:
  - strobe A at edge 2
  - strobe OP at edge 2+(G+2)
  - strobe B at edge 2+2(G+2)
  - WAIT_DONE entered at edge 3(G+2)+1
  - rsp_valid=1 one edge after done is seen
  - For G=2 with done already high: rsp_valid at edge 14.
- A command offered while not in IDLE is not accepted; cmd_valid must hold.

Optional Feature:
KEYSEQ_TIMEOUT_EN
- Defined: a counter runs in WAIT_DONE. If done stays 0 for TIMEOUT_CYCLES cycles, go to RESP with rsp_err=1 and rsp_result=0. The counter clears on entering WAIT_DONE.
- Undefined: no counter or timeout logic; WAIT_DONE waits indefinitely for done.

Test Plan:
1. Reset, then cmd a=3, op=00, b=4, with the calculator model attached -> key sequence 3,0,4, each with a 1-cycle strobe and 2-cycle gaps; rsp_valid at edge 14; rsp_result=8'd7; rsp_err=0.
2. a=15, op=10, b=15 -> rsp_result=8'd225. Then a=3, op=01, b=5 -> rsp_result=8'hFE. Both commands issued back-to-back with rsp_ready=1.
3. op=11, a=1, b=1 -> valid_key never asserted; rsp_valid 1 edge after accept; rsp_err=1; rsp_result=0.
4. rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_valid/rsp_result stable; cmd_ready=0 throughout; IDLE one cycle after rsp_ready=1.
5. rstn pulsed low during GAP_OP -> valid_key=0, key=0, rsp_valid=0 immediately; cmd_ready=1 after release; a new command completes correctly.
6. With KEYSEQ_TIMEOUT_EN and done tied 0 -> rsp_err=1, rsp_result=0, TIMEOUT_CYCLES edges after entering WAIT_DONE. Without the macro -> no response after 100 cycles.

Source files
------------

// File: rtl/calc_key_sequencer.sv
// Keypad-protocol initiator for the FSMD calculator: sends A, op, B as single-cycle key strobes,
// waits for done and returns the result. Define KEYSEQ_TIMEOUT_EN to bound the wait for done.
module calc_key_sequencer #(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [3:0] cmd_a_i,
  input  logic [1:0] cmd_op_i,
  input  logic [3:0] cmd_b_i,
  output logic       valid_key_o,
  output logic [3:0] key_o,
  input  logic       done_i,
  input  logic [7:0] result_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_result_o,
  output logic       rsp_err_o
);

  typedef enum logic [3:0] {
    StIdle, StLoadA, StStbA, StGapA, StLoadOp, StStbOp, StGapOp,
    StLoadB, StStbB, StGapB, StWaitDone, StResp
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [3:0]  b_q, b_d;
  logic [3:0]  key_q, key_d;
  logic        valid_key_q, valid_key_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_result_q, rsp_result_d;
  logic        rsp_err_q, rsp_err_d;
  logic        gap_last;

`ifdef KEYSEQ_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
`endif

  assign gap_last = (gap_cnt_q == 4'(GAP_CYCLES - 1));

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    b_d          = b_q;
    key_d        = key_q;
    valid_key_d  = 1'b0;
    gap_cnt_d    = '0;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
`ifdef KEYSEQ_TIMEOUT_EN
    to_cnt_d     = '0;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          op_d = cmd_op_i;
          b_d  = cmd_b_i;
          if (cmd_op_i == 2'b11) begin
            // Reserved opcode: answer with an error without touching the keypad.
            state_d      = StResp;
            rsp_valid_d  = 1'b1;
            rsp_err_d    = 1'b1;
            rsp_result_d = 8'h00;
          end else begin
            state_d = StLoadA;
            key_d   = cmd_a_i;
          end
        end
      end
      StLoadA: begin
        state_d     = StStbA;
        valid_key_d = 1'b1;
      end
      StStbA: state_d = StGapA;
      StGapA: begin
        if (gap_last) begin
          state_d = StLoadOp;
          key_d   = {2'b00, op_q};
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      StLoadOp: begin
        state_d     = StStbOp;
        valid_key_d = 1'b1;
      end
      StStbOp: state_d = StGapOp;
      StGapOp: begin
        if (gap_last) begin
          state_d = StLoadB;
          key_d   = b_q;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      StLoadB: begin
        state_d     = StStbB;
        valid_key_d = 1'b1;
      end
      StStbB: state_d = StGapB;
      StGapB: begin
        if (gap_last) begin
          state_d = StWaitDone;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      StWaitDone: begin
        if (done_i) begin
          state_d      = StResp;
          rsp_valid_d  = 1'b1;
          rsp_result_d = result_i;
          rsp_err_d    = 1'b0;
`ifdef KEYSEQ_TIMEOUT_EN
        end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          state_d      = StResp;
          rsp_valid_d  = 1'b1;
          rsp_result_d = 8'h00;
          rsp_err_d    = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
`endif
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      op_q         <= 2'b00;
      b_q          <= 4'h0;
      key_q        <= 4'h0;
      valid_key_q  <= 1'b0;
      gap_cnt_q    <= 4'h0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 8'h00;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      b_q          <= b_d;
      key_q        <= key_d;
      valid_key_q  <= valid_key_d;
      gap_cnt_q    <= gap_cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

`ifdef KEYSEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  assign cmd_ready_o  = (state_q == StIdle);
  assign valid_key_o  = valid_key_q;
  assign key_o        = key_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_err_o    = rsp_err_q;

endmodule
